// File: rtl/cla_adder_pipelined.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 forms effective operands and bit/group propagate-generate terms.
// Stage 2 resolves group carries by lookahead, then bit carries inside each group.
module cla_adder_pipelined #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  // Flattened lookahead carry after n positions:
  //   c_n = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]c0
  // Written as a sum of products so no term depends on a previous carry.
  function automatic logic la_carry(input logic [WIDTH-1:0] gv,
                                    input logic [WIDTH-1:0] pv,
                                    input logic             c0,
                                    input int               n);
    logic res;
    logic term;
    res = c0;
    for (int l = 0; l < WIDTH; l++)
      if (l < n) res = res & pv[l];
    for (int m = 0; m < WIDTH; m++) begin
      term = (m < n) ? gv[m] : 1'b0;
      for (int l = 0; l < WIDTH; l++)
        if (l > m && l < n) term = term & pv[l];
      res = res | term;
    end
    return res;
  endfunction

  // Handshake: each stage advances when the stage after it is free or draining.
  logic adv1, adv2;
  logic s1_valid;

  assign adv2     = !out_valid | out_ready;
  assign adv1     = !s1_valid | adv2;
  assign in_ready = adv1;

  // Stage 1 combinational terms.
  logic [WIDTH-1:0] be;
  logic             cin_e;
  logic [WIDTH-1:0] p_c, g_c;
  logic [NG-1:0]    gp_c, gg_c;

  assign be    = b ^ {WIDTH{sub}};
  assign cin_e = ci ^ sub;
  assign p_c   = a ^ be;
  assign g_c   = a & be;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp_pg
      assign gp_c[gi] = &p_c[gi*GROUP +: GROUP];
      assign gg_c[gi] = la_carry(WIDTH'(g_c[gi*GROUP +: GROUP]),
                                 WIDTH'(p_c[gi*GROUP +: GROUP]), 1'b0, GROUP);
    end
  endgenerate

  // Stage 1 registers.
  logic [WIDTH-1:0] p_reg, g_reg;
  logic [NG-1:0]    gp_reg, gg_reg;
  logic             cin_reg, a_msb_reg, be_msb_reg;

  // Capture operand terms whenever stage 1 is free to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      p_reg      <= '0;
      g_reg      <= '0;
      gp_reg     <= '0;
      gg_reg     <= '0;
      cin_reg    <= 1'b0;
      a_msb_reg  <= 1'b0;
      be_msb_reg <= 1'b0;
    end else if (adv1) begin
      s1_valid   <= in_valid;
      p_reg      <= p_c;
      g_reg      <= g_c;
      gp_reg     <= gp_c;
      gg_reg     <= gg_c;
      cin_reg    <= cin_e;
      a_msb_reg  <= a[MSB];
      be_msb_reg <= be[MSB];
    end
  end

  // Stage 2: group carries from group P/G, then bit carries from each group carry-in.
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] c_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c, ovf_c;

  generate
    for (gi = 0; gi <= NG; gi++) begin : g_grp_carry
      assign grp_c[gi] = la_carry(WIDTH'(gg_reg), WIDTH'(gp_reg), cin_reg, gi);
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit_carry
      assign c_c[gi] = la_carry(WIDTH'(g_reg[(gi/GROUP)*GROUP +: GROUP]),
                                WIDTH'(p_reg[(gi/GROUP)*GROUP +: GROUP]),
                                grp_c[gi/GROUP], gi % GROUP);
    end
  endgenerate

  assign sum_c  = p_reg ^ c_c;
  assign cout_c = grp_c[NG];
  assign ovf_c  = (a_msb_reg == be_msb_reg) & (sum_c[MSB] != a_msb_reg);

  // Result register; holds while downstream stalls a valid result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      sum       <= sum_c;
      cout      <= cout_c;
      ovf       <= ovf_c;
    end
  end

endmodule

// File: tb/tb_cla_adder_pipelined.sv
// Bench for cla_adder_pipelined: three configurations driven together, each
// checked every cycle against an arithmetic model of an in-order 2-slot pipe.
module tb_cla_adder_pipelined;

  localparam int W0 = 16, G0 = 4;
  localparam int W1 = 8,  G1 = 2;
  localparam int W2 = 32, G2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int wid [3] = '{W0, W1, W2};

  logic [31:0] a_s [3];
  logic [31:0] b_s [3];
  logic [31:0] sum_s [3];
  logic [2:0]  ci_v, sub_v, in_valid_v, out_ready_v;
  logic [2:0]  in_ready_v, out_valid_v, cout_v, ovf_v;
  logic [W0-1:0] sum0;
  logic [W1-1:0] sum1;
  logic [W2-1:0] sum2;

  assign sum_s[0] = 32'(sum0);
  assign sum_s[1] = 32'(sum1);
  assign sum_s[2] = sum2;

  cla_adder_pipelined #(.WIDTH(W0), .GROUP(G0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_s[0][W0-1:0]), .b(b_s[0][W0-1:0]), .ci(ci_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]));

  cla_adder_pipelined #(.WIDTH(W1), .GROUP(G1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_s[1][W1-1:0]), .b(b_s[1][W1-1:0]), .ci(ci_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]));

  cla_adder_pipelined #(.WIDTH(W2), .GROUP(G2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_s[2]), .b(b_s[2]), .ci(ci_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]));

  typedef struct {
    logic [33:0] exp;
    int          acc;
    bit          pin;
    logic [33:0] pin_val;
  } entry_t;

  entry_t q [3][$];

  // Driver-to-monitor side channel.
  bit          pin_en = 1'b0;
  logic [33:0] pin_val = '0;
  int          drv_timeouts = 0;
  bit          final_req = 1'b0;

  function automatic logic [31:0] mask32(int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [33:0] pk(logic o, logic c, logic [31:0] s);
    return {o, c, s};
  endfunction

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b,
                                        logic ci, logic sub);
    longint unsigned mask, au, bu, be, full;
    longint sa, sb, sr, lim;
    logic c, o;
    mask = (64'd1 << w) - 64'd1;
    au   = {32'd0, a} & mask;
    bu   = {32'd0, b} & mask;
    be   = sub ? (~bu & mask) : bu;
    full = au + be + {63'd0, ci ^ sub};
    c    = full[w];
    lim  = longint'(64'd1 << (w - 1));
    sa   = (au >= 64'(lim)) ? longint'(au) - 2 * lim : longint'(au);
    sb   = (bu >= 64'(lim)) ? longint'(bu) - 2 * lim : longint'(bu);
    sr   = sub ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
    o    = (sr >= lim) || (sr < -lim);
    return {o, c, 32'(full & mask)};
  endfunction

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit stall_prev [3];
  logic [33:0] held [3];

  task automatic chk(string name, int d, logic [33:0] got, logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, got, exp);
    end
  endtask

  // Monitor/compare: every cycle, for every instance.
  always @(negedge clk) begin
    logic [33:0] got;
    logic        ov_exp;
    entry_t      e;
    int          n;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      got = {ovf_v[d], cout_v[d], sum_s[d] & mask32(wid[d])};
      if (rst) begin
        chk("reset_out_valid", d, 34'(out_valid_v[d]), 34'(0));
        chk("reset_outputs", d, got, 34'(0));
        q[d].delete();
        stall_prev[d] = 1'b0;
      end else begin
        n = q[d].size();
        chk("in_ready", d, 34'(in_ready_v[d]), 34'((n < 2) || out_ready_v[d]));
        ov_exp = 1'b0;
        if (n > 0) ov_exp = (cyc - q[d][0].acc) >= 2;
        chk("out_valid", d, 34'(out_valid_v[d]), 34'(ov_exp));
        if (stall_prev[d]) chk("stall_hold", d, got, held[d]);
        if (out_valid_v[d] && out_ready_v[d]) begin
          if (n == 0) begin
            chk("spurious_output", d, 34'(out_valid_v[d]), 34'(0));
          end else begin
            e = q[d].pop_front();
            chk("result", d, got, e.exp);
            if (e.pin) chk("pinned_result", d, got, e.pin_val);
          end
        end
        stall_prev[d] = out_valid_v[d] & !out_ready_v[d];
        held[d] = got;
        if (in_valid_v[d] && in_ready_v[d]) begin
          e.exp     = model(wid[d], a_s[d], b_s[d], ci_v[d], sub_v[d]);
          e.acc     = cyc;
          e.pin     = (d == 0) && pin_en;
          e.pin_val = pin_val;
          q[d].push_back(e);
        end
      end
    end
    if (final_req) begin
      chk("driver_timeouts", 0, 34'(drv_timeouts), 34'(0));
      for (int d = 0; d < 3; d++) chk("drained", d, 34'(q[d].size()), 34'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op on instance 0 with a hand-computed expected result.
  task automatic op0(logic [31:0] a, logic [31:0] b, logic ci, logic sub,
                     logic [33:0] pv);
    bit acc;
    acc = 1'b0;
    a_s[0] = a; b_s[0] = b; ci_v[0] = ci; sub_v[0] = sub;
    pin_val = pv; pin_en = 1'b1; in_valid_v[0] = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_valid_v[0] & in_ready_v[0];
      tick();
    end
    if (!acc) drv_timeouts++;
    in_valid_v[0] = 1'b0;
    pin_en = 1'b0;
    repeat (4) tick();
  endtask

  function automatic logic [31:0] rnd_op(int w);
    logic [31:0] m;
    m = mask32(w);
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return m;
      2: return (32'd1 << (w - 1));
      3: return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  // Driver.
  initial begin
    int idx;
    bit acc;
    for (int d = 0; d < 3; d++) begin
      a_s[d] = '0;
      b_s[d] = '0;
    end
    ci_v = '0; sub_v = '0; in_valid_v = '0; out_ready_v = '1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Directed vectors on the 16-bit / 4-bit-group instance.
    op0(32'hFFFF, 32'h0001, 1'b0, 1'b0, pk(1'b0, 1'b1, 32'h0000));
    op0(32'h7FFF, 32'h0000, 1'b1, 1'b0, pk(1'b1, 1'b0, 32'h8000));
    op0(32'h8000, 32'h0001, 1'b0, 1'b1, pk(1'b1, 1'b1, 32'h7FFF));
    op0(32'h8000, 32'h0001, 1'b1, 1'b1, pk(1'b1, 1'b1, 32'h7FFE));

    // Four back-to-back ops against a 4-cycle downstream stall.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready_v[0] = (c >= 4);
      in_valid_v[0]  = (idx < 4);
      a_s[0] = 32'(idx + 1); b_s[0] = 32'(idx + 1);
      ci_v[0] = 1'b0; sub_v[0] = 1'b0;
      pin_en  = (idx < 4);
      pin_val = 34'(2 * (idx + 1));
      @(negedge clk);
      acc = in_valid_v[0] & in_ready_v[0];
      tick();
      if (acc) idx++;
    end
    if (idx != 4) drv_timeouts++;
    in_valid_v[0] = 1'b0; pin_en = 1'b0; out_ready_v[0] = 1'b1;
    repeat (3) tick();

    // Two ops in flight, then reset mid-cycle; neither may ever appear.
    out_ready_v[0] = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      in_valid_v[0] = 1'b1;
      a_s[0] = 32'(16'h1230 + idx); b_s[0] = 32'h0101;
      @(negedge clk);
      acc = in_valid_v[0] & in_ready_v[0];
      tick();
      if (acc) idx++;
    end
    if (idx != 2) drv_timeouts++;
    in_valid_v[0] = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    out_ready_v[0] = 1'b1;
    repeat (5) tick();

    // Randomised traffic on all three configurations.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid_v[d]  = ($urandom_range(0, 3) != 0);
        out_ready_v[d] = ($urandom_range(0, 3) != 0);
        a_s[d] = rnd_op(wid[d]);
        b_s[d] = rnd_op(wid[d]);
        ci_v[d]  = 1'($urandom_range(0, 1));
        sub_v[d] = 1'($urandom_range(0, 1));
      end
      tick();
    end

    in_valid_v = '0;
    out_ready_v = '1;
    repeat (10) tick();
    final_req = 1'b1;
  end

endmodule
